// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq: state in (valid/ready/bypass) and state out (valid/ready).
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES (Inv)MixColumns: one shared column multiplier applied to columns 0..3 in turn.
// Bypass sends the accepted state straight to the output register for the final round.
module mix_columns_seq #(
  parameter bit INVERSE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  mix_columns_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Circulant product: r[i] = m0[i] ^ m1[i+1] ^ m2[i+2] ^ m3[i+3], indices mod 4.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0]  a  [4];
    logic [7:0]  m0 [4];
    logic [7:0]  m1 [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m3 [4];
    logic [7:0]  x2, x4, x8;
    logic [1:0]  k;
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      k     = 2'(i);
      a[k]  = c[8*(3-i) +: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      if (INVERSE) begin
        m0[k] = x8 ^ x4 ^ x2;
        m1[k] = x8 ^ x2 ^ a[k];
        m2[k] = x8 ^ x4 ^ a[k];
        m3[k] = x8 ^ a[k];
      end else begin
        m0[k] = x2;
        m1[k] = x2 ^ a[k];
        m2[k] = a[k];
        m3[k] = a[k];
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      k = 2'(i);
      r[8*(3-i) +: 8] = m0[k] ^ m1[k + 2'd1] ^ m2[k + 2'd2] ^ m3[k + 2'd3];
    end
    return r;
  endfunction

  always_comb begin
    col_in = st_q[127:96];
    unique case (cnt_q)
      2'd0: col_in = st_q[127:96];
      2'd1: col_in = st_q[95:64];
      2'd2: col_in = st_q[63:32];
      2'd3: col_in = st_q[31:0];
    endcase
  end

  assign col_out = mix_col(col_in);

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          st_d    = bus.in_data;
          cnt_d   = 2'd0;
          state_d = bus.in_bypass ? StDone : StBusy;
        end
      end
      StBusy: begin
        unique case (cnt_q)
          2'd0: st_d[127:96] = col_out;
          2'd1: st_d[95:64]  = col_out;
          2'd2: st_d[63:32]  = col_out;
          2'd3: st_d[31:0]   = col_out;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      st_q    <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = st_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: forward and inverse instances, scoreboard queues per instance.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mix_columns_seq_if bus_f ();
  mix_columns_seq_if bus_i ();

  mix_columns_seq #(.INVERSE(1'b0)) u_fwd (.clk(clk), .rst_n(rst_n), .bus(bus_f.slave));
  mix_columns_seq #(.INVERSE(1'b1)) u_inv (.clk(clk), .rst_n(rst_n), .bus(bus_i.slave));

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] q_f [$];
  logic [127:0] q_i [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference multiply by shift-and-add, independent of the RTL's fixed xtime chains.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [31:0]  col;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], a[k]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic drive_in(input bit inv, input logic v, input logic [127:0] d, input logic b);
    if (inv) begin
      bus_i.in_valid = v; bus_i.in_data = d; bus_i.in_bypass = b;
    end else begin
      bus_f.in_valid = v; bus_f.in_data = d; bus_f.in_bypass = b;
    end
  endtask

  task automatic set_oready(input bit inv, input logic r);
    if (inv) bus_i.out_ready = r;
    else     bus_f.out_ready = r;
  endtask

  function automatic logic rdy(input bit inv);
    return inv ? bus_i.in_ready : bus_f.in_ready;
  endfunction

  function automatic logic ov(input bit inv);
    return inv ? bus_i.out_valid : bus_f.out_valid;
  endfunction

  function automatic logic [127:0] od(input bit inv);
    return inv ? bus_i.out_data : bus_f.out_data;
  endfunction

  // Holds in_valid until an accept edge; returns at accept edge + 1.
  task automatic send(input bit inv, input logic [127:0] d, input logic b,
                      input logic [127:0] exp);
    logic r;
    bit   ok;
    ok = 1'b0;
    drive_in(inv, 1'b1, d, b);
    for (int n = 0; n < 50; n++) begin
      r = rdy(inv);
      @(posedge clk); #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    drive_in(inv, 1'b0, '0, 1'b0);
    chk("send_accept", 128'(ok), 128'd1);
    if (ok) begin
      if (inv) q_i.push_back(exp);
      else     q_f.push_back(exp);
    end
  endtask

  // rise = edges after the accept edge at which out_valid is first seen high.
  task automatic recv(input bit inv, input string tag, output logic [127:0] got,
                      output int rise);
    logic         v;
    logic [127:0] d;
    logic [127:0] exp;
    bit           ok;
    ok   = 1'b0;
    rise = -1;
    got  = '0;
    set_oready(inv, 1'b1);
    for (int n = 0; n < 50; n++) begin
      v = ov(inv);
      d = od(inv);
      @(posedge clk); #1;
      if (v) begin
        ok   = 1'b1;
        rise = n;
        got  = d;
        break;
      end
    end
    set_oready(inv, 1'b0);
    chk({tag, "_handshake"}, 128'(ok), 128'd1);
    if (ok) begin
      exp = inv ? q_i.pop_front() : q_f.pop_front();
      chk(tag, got, exp);
    end
  endtask

  logic [127:0] got, s, t, exp_a;
  int           rise;
  bit           found;

  initial begin
    rst_n = 1'b0;
    drive_in(1'b0, 1'b0, '0, 1'b0);
    drive_in(1'b1, 1'b0, '0, 1'b0);
    set_oready(1'b0, 1'b0);
    set_oready(1'b1, 1'b0);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", 128'(bus_f.out_valid), 128'd0);
    chk("rst_out_data", bus_f.out_data, 128'd0);
    chk("rst_in_ready", 128'(bus_f.in_ready), 128'd1);
    chk("rst_inv_in_ready", 128'(bus_i.in_ready), 128'd1);
    rst_n = 1'b1;

    // Forward single column
    send(1'b0, {32'hdb135345, 96'h0}, 1'b0, {32'h8e4da1bc, 96'h0});
    recv(1'b0, "fwd_col0", got, rise);
    chk("fwd_col0_latency", 128'(rise), 128'd4);

    // FIPS-197 round 1
    send(1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
         128'h046681e5e0cb199a48f8d37a2806264c);
    recv(1'b0, "fwd_fips", got, rise);

    // Bypass: output register loaded on the accept edge itself
    send(1'b0, 128'h00112233445566778899aabbccddeeff, 1'b1,
         128'h00112233445566778899aabbccddeeff);
    recv(1'b0, "bypass", got, rise);
    chk("bypass_latency", 128'(rise), 128'd0);
    for (int i = 0; i < 3; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(1'b0, s, 1'b1, s);
      recv(1'b0, "bypass_b2b", got, rise);
    end

    // Backpressure with a stalled second state
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_a = mix_state(s, 1'b0);
    send(1'b0, s, 1'b0, exp_a);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus_f.out_valid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("bp_done_reached", 128'(found), 128'd1);
    drive_in(1'b0, 1'b1, t, 1'b0);
    for (int n = 0; n < 10; n++) begin
      chk("bp_data_stable", bus_f.out_data, exp_a);
      chk("bp_in_ready_low", 128'(bus_f.in_ready), 128'd0);
      @(posedge clk); #1;
    end
    chk("bp_data", bus_f.out_data, q_f.pop_front());
    bus_f.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_f.out_ready = 1'b0;
    chk("bp_after_hs_in_ready", 128'(bus_f.in_ready), 128'd1);
    chk("bp_after_hs_out_valid", 128'(bus_f.out_valid), 128'd0);
    @(posedge clk); #1;
    chk("bp_second_accepted", 128'(bus_f.in_ready), 128'd0);
    drive_in(1'b0, 1'b0, '0, 1'b0);
    q_f.push_back(mix_state(t, 1'b0));
    recv(1'b0, "bp_second", got, rise);
    chk("bp_second_latency", 128'(rise), 128'd4);

    // Reset after E2: partial work discarded
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(1'b0, s, 1'b0, mix_state(s, 1'b0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus_f.out_valid), 128'd0);
    chk("mid_rst_out_data", bus_f.out_data, 128'd0);
    chk("mid_rst_cnt", 128'(u_fwd.cnt_q), 128'd0);
    chk("mid_rst_in_ready", 128'(bus_f.in_ready), 128'd1);
    q_f.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("post_rst_no_valid", 128'(bus_f.out_valid), 128'd0);
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(1'b0, s, 1'b0, mix_state(s, 1'b0));
    recv(1'b0, "post_rst", got, rise);

    // Inverse single column
    send(1'b1, {32'h8e4da1bc, 96'h0}, 1'b0, {32'hdb135345, 96'h0});
    recv(1'b1, "inv_col0", got, rise);
    chk("inv_col0_latency", 128'(rise), 128'd4);

    // 01010101 is a fixed point of both matrices
    send(1'b0, {4{32'h01010101}}, 1'b0, {4{32'h01010101}});
    recv(1'b0, "fwd_ones", got, rise);
    send(1'b1, {4{32'h01010101}}, 1'b0, {4{32'h01010101}});
    recv(1'b1, "inv_ones", got, rise);

    // Round trip: forward DUT output fed to inverse DUT must return the original
    for (int i = 0; i < 4; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(1'b0, s, 1'b0, mix_state(s, 1'b0));
      recv(1'b0, "rt_fwd", got, rise);
      send(1'b1, got, 1'b0, s);
      recv(1'b1, "rt_inv", got, rise);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
